// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / redirect / data-memory-wait hazard and stall control
// Optional performance counters: define HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             useRs1_id,
  input  logic             useRs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             memRead_ex,
  input  logic             branchTaken_ex,
  input  logic             jump_ex,
  input  logic             memReq_mem,
  input  logic             dmemReady,
  output logic             ctrl_select,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexWrite,
  output logic             exmemWrite,
  output logic             memwbWrite,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

  state_t      state, stateNext;
  logic [15:0] waitCnt;
  logic [16:0] waitInc;
  logic        timeoutQ;
  logic        freeze, redirect, loadUse, rs1Hit, rs2Hit;

  assign freeze   = memReq_mem & ~dmemReady;
  assign redirect = branchTaken_ex | jump_ex;
  assign rs1Hit   = useRs1_id & (rs1_id == rd_ex);
  assign rs2Hit   = useRs2_id & (rs2_id == rd_ex);
  assign loadUse  = memRead_ex & (rd_ex != 5'd0) & (rs1Hit | rs2Hit);
  assign waitInc  = {1'b0, waitCnt} + 17'd1;

  // Outputs are gated by rst_n directly so reset forces them regardless of inputs.
  always_comb begin
    stateNext   = state;
    ctrl_select = 1'b1;
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    ifidFlush   = 1'b0;
    idexWrite   = 1'b1;
    exmemWrite  = 1'b1;
    memwbWrite  = 1'b1;

    case (state)
      RUN:      if (freeze) stateNext = MEM_WAIT;
      MEM_WAIT: if (dmemReady) stateNext = RUN;
      default:  stateNext = RUN;
    endcase

    if (!rst_n) begin
      ctrl_select = 1'b0;
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      ifidFlush   = 1'b1;
      idexWrite   = 1'b0;
      exmemWrite  = 1'b0;
      memwbWrite  = 1'b0;
    end else if (freeze) begin
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      idexWrite   = 1'b0;
      exmemWrite  = 1'b0;
      memwbWrite  = 1'b0;
    end else if (redirect) begin
      ifidFlush   = 1'b1;
      ctrl_select = 1'b0;
    end else if (loadUse) begin
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      ctrl_select = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      waitCnt  <= '0;
      timeoutQ <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == RUN) begin
        if (freeze) waitCnt <= '0;
      end else begin
        if (waitCnt != 16'hFFFF) waitCnt <= waitInc[15:0];
        // Sticky; the access itself is never aborted.
        if (waitInc >= TIMEOUT_L) timeoutQ <= 1'b1;
      end
    end
  end

  assign memTimeout = timeoutQ;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stallQ, flushQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallQ <= '0;
      flushQ <= '0;
    end else begin
      if ((freeze | (loadUse & ~redirect)) && (stallQ != '1)) stallQ <= stallQ + CNT_ONE;
      if (redirect && !freeze && (flushQ != '1)) flushQ <= flushQ + CNT_ONE;
    end
  end

  assign stallCycles = stallQ;
  assign flushCount  = flushQ;
`else
  assign stallCycles = '0;
  assign flushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - randomized and directed bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic useRs1_id, useRs2_id, memRead_ex, branchTaken_ex, jump_ex, memReq_mem, dmemReady;
  logic ctrl_select, pcWrite, ifidWrite, ifidFlush, idexWrite, exmemWrite, memwbWrite, memTimeout;
  logic [CNT_W-1:0] stallCycles, flushCount;

  int nChecks = 0;
  int nFails  = 0;

  hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .useRs1_id(useRs1_id), .useRs2_id(useRs2_id),
    .rd_ex(rd_ex), .memRead_ex(memRead_ex), .branchTaken_ex(branchTaken_ex), .jump_ex(jump_ex),
    .memReq_mem(memReq_mem), .dmemReady(dmemReady),
    .ctrl_select(ctrl_select), .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .idexWrite(idexWrite), .exmemWrite(exmemWrite), .memwbWrite(memwbWrite),
    .memTimeout(memTimeout), .stallCycles(stallCycles), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  // {ctrl_select, pcWrite, ifidWrite, ifidFlush, idexWrite, exmemWrite, memwbWrite}
  function automatic logic [6:0] ctrlVec();
    return {ctrl_select, pcWrite, ifidWrite, ifidFlush, idexWrite, exmemWrite, memwbWrite};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: wait-cycle length and event counts as plain integers.
  bit mWait = 0;
  int mWaitLen = 0;
  bit mTimeout = 0;
  int mStall = 0, mFlush = 0;

  always @(negedge clk) begin
    bit fz, rdr, lu;
    logic [6:0] exp;
    if (!rst_n) begin
      mWait = 0; mWaitLen = 0; mTimeout = 0; mStall = 0; mFlush = 0;
      chk("reset_ctrl", ctrlVec(), 7'b0001000);
      chk("reset_timeout", memTimeout, 0);
      chk("reset_stall", stallCycles, 0);
      chk("reset_flush", flushCount, 0);
    end else begin
      fz  = memReq_mem && !dmemReady;
      rdr = branchTaken_ex || jump_ex;
      lu  = memRead_ex && rd_ex != 0 &&
            ((useRs1_id && rs1_id == rd_ex) || (useRs2_id && rs2_id == rd_ex));
      if (fz)       exp = 7'b1000000;
      else if (rdr) exp = 7'b0111111;
      else if (lu)  exp = 7'b0000111;
      else          exp = 7'b1110111;
      chk("ctrl", ctrlVec(), exp);
      chk("timeout", memTimeout, mTimeout);
`ifdef HAZARD_PERF_CNT_EN
      chk("stallCycles", stallCycles, mStall);
      chk("flushCount", flushCount, mFlush);
      if (fz || (lu && !rdr)) mStall = (mStall < 65535) ? mStall + 1 : mStall;
      if (rdr && !fz)         mFlush = (mFlush < 65535) ? mFlush + 1 : mFlush;
`else
      chk("stallCycles_off", stallCycles, 0);
      chk("flushCount_off", flushCount, 0);
`endif
      if (!mWait) begin
        if (fz) begin mWait = 1; mWaitLen = 0; end
      end else begin
        mWaitLen++;
        if (mWaitLen >= TIMEOUT) mTimeout = 1;
        if (dmemReady) mWait = 0;
      end
    end
  end

  task automatic idle();
    rs1_id = 0; rs2_id = 0; rd_ex = 0; useRs1_id = 0; useRs2_id = 0;
    memRead_ex = 0; branchTaken_ex = 0; jump_ex = 0; memReq_mem = 0; dmemReady = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0, f0;
    rst_n = 0;
    idle();
    memReq_mem = 1; branchTaken_ex = 1;
    #1;
    chk("lit_reset_ctrl", ctrlVec(), 7'b0001000);
    step(); step();
    idle();
    rst_n = 1;
    #1;
    chk("lit_idle", ctrlVec(), 7'b1110111);

    // Load x5 in EX, ID reads rs2=x5: one-cycle stall, then bubble lets it go.
    step();
    memRead_ex = 1; rd_ex = 5; useRs2_id = 1; rs2_id = 5;
    #1;
    chk("lit_loaduse", ctrlVec(), 7'b0000111);
    step();
    memRead_ex = 0;
    #1;
    chk("lit_after_bubble", ctrlVec(), 7'b1110111);

    // Load to x0 never stalls.
    step();
    idle(); memRead_ex = 1; rd_ex = 0; useRs1_id = 1; rs1_id = 0;
    #1;
    chk("lit_x0_no_stall", ctrl_select, 1);

    // Redirect beats load-use.
    step();
    idle(); memRead_ex = 1; rd_ex = 7; useRs1_id = 1; rs1_id = 7; branchTaken_ex = 1;
    #1;
    chk("lit_redirect_ctrl", ctrlVec(), 7'b0111111);
    s0 = stallCycles; f0 = flushCount;
    step();
    idle();
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("lit_redirect_flush", flushCount, f0 + 1);
    chk("lit_redirect_stall", stallCycles, s0);
`else
    chk("lit_redirect_flush_off", flushCount, 0);
    chk("lit_redirect_stall_off", stallCycles, 0);
`endif

    // Three-cycle freeze.
    s0 = stallCycles;
    memReq_mem = 1; dmemReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lit_freeze", ctrlVec(), 7'b1000000);
      step();
    end
    dmemReady = 1;
    #1;
    chk("lit_freeze_release", ctrlVec(), 7'b1110111);
    step();
    idle();
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("lit_freeze_stall", stallCycles, s0 + 3);
`else
    chk("lit_freeze_stall_off", stallCycles, 0);
`endif
    step();

    // Timeout: sets after the 4th MEM_WAIT cycle, sticky until reset.
    memReq_mem = 1; dmemReady = 0;
    for (int i = 0; i < 4; i++) step();
    chk("lit_timeout_early", memTimeout, 0);
    step();
    chk("lit_timeout_set", memTimeout, 1);
    step(); step();
    chk("lit_timeout_sticky", memTimeout, 1);
    rst_n = 0;
    #1;
    chk("lit_timeout_reset", memTimeout, 0);
    chk("lit_midwait_reset_ctrl", ctrlVec(), 7'b0001000);
    step(); step();
    rst_n = 1;
    #1;
    chk("lit_release_in_freeze", ctrlVec(), 7'b1000000);
    dmemReady = 1;
    step();
    idle();
    step();

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      rs1_id         = 5'($urandom_range(0, 3));
      rs2_id         = 5'($urandom_range(0, 3));
      rd_ex          = 5'($urandom_range(0, 3));
      useRs1_id      = 1'($urandom);
      useRs2_id      = 1'($urandom);
      memRead_ex     = 1'($urandom);
      branchTaken_ex = ($urandom_range(0, 5) == 0);
      jump_ex        = ($urandom_range(0, 7) == 0);
      memReq_mem     = 1'($urandom);
      dmemReady      = ($urandom_range(0, 9) < 6);
      rst_n          = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1;
    idle();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
